// File: rtl/key_debounce_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : key_debounce_multi                                            |
// | Purpose  : N-channel key synchroniser/debouncer with press, release,     |
// |            long-press and auto-repeat strobes plus a lowest-index       |
// |            registered priority encoder of accepted presses.             |
// | Revision : 1.0 - initial multi-channel release                           |
// +--------------------------------------------------------------------------+
module key_debounce_multi #(
   parameter int N_KEY      = 4,
   parameter int CNT_MAX    = 999_999,
   parameter int LONG_MAX   = 49_999_999,
   parameter int REPEAT_MAX = 9_999_999,
   parameter int REPEAT_EN  = 1,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                                          sys_clk,
   input  logic                                          sys_rst,
   input  logic [N_KEY-1:0]                              key_in,
   output logic [N_KEY-1:0]                              key_press,
   output logic [N_KEY-1:0]                              key_release,
   output logic [N_KEY-1:0]                              key_long,
   output logic [N_KEY-1:0]                              key_repeat,
   output logic [N_KEY-1:0]                              key_held,
   output logic                                          key_vld,
   output logic [((N_KEY > 1) ? $clog2(N_KEY) : 1)-1:0]  key_code
);

   localparam int   c_CW      = (N_KEY > 1) ? $clog2(N_KEY) : 1;
   localparam int   c_DW      = $clog2(CNT_MAX);
   localparam int   c_HW      = $clog2(LONG_MAX);
   localparam int   c_RW      = $clog2(REPEAT_MAX);
   localparam logic c_ACT_LOW = (ACTIVE_LOW != 0);
   localparam logic c_REP_EN  = (REPEAT_EN != 0);

   localparam logic [c_DW-1:0] c_D_LAST = c_DW'(CNT_MAX - 1);
   localparam logic [c_HW-1:0] c_H_LAST = c_HW'(LONG_MAX - 1);
   localparam logic [c_RW-1:0] c_R_LAST = c_RW'(REPEAT_MAX - 1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_PRESS_DB   = 3'd1,
      S_HELD       = 3'd2,
      S_LONG       = 3'd3,
      S_RELEASE_DB = 3'd4
   } state_t;

   // Reset loads the released level so a key held through reset re-presses.
   logic [N_KEY-1:0] r_sync1;
   logic [N_KEY-1:0] r_sync2;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_sync1 <= {N_KEY{c_ACT_LOW}};
         r_sync2 <= {N_KEY{c_ACT_LOW}};
      end else begin
         r_sync1 <= key_in;
         r_sync2 <= r_sync1;
      end
   end

   generate
      for (genvar i = 0; i < N_KEY; i++) begin : g_ch
         state_t            r_state;
         logic [c_DW-1:0]   r_dcnt;
         logic [c_HW-1:0]   r_hcnt;
         logic [c_RW-1:0]   r_rcnt;
         logic              r_was_long;
         logic              r_press;
         logic              r_release;
         logic              r_long;
         logic              r_repeat;
         logic              r_held;
         logic              w_act;

         assign w_act = r_sync2[i] ^ c_ACT_LOW;

         always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
               r_state    <= S_IDLE;
               r_dcnt     <= '0;
               r_hcnt     <= '0;
               r_rcnt     <= '0;
               r_was_long <= 1'b0;
               r_press    <= 1'b0;
               r_release  <= 1'b0;
               r_long     <= 1'b0;
               r_repeat   <= 1'b0;
               r_held     <= 1'b0;
            end else begin
               r_press   <= 1'b0;
               r_release <= 1'b0;
               r_long    <= 1'b0;
               r_repeat  <= 1'b0;
               case (r_state)
                  S_IDLE: begin
                     if (w_act) begin
                        r_state <= S_PRESS_DB;
                        r_dcnt  <= '0;
                     end
                  end
                  S_PRESS_DB: begin
                     if (!w_act) begin
                        r_state <= S_IDLE;
                        r_dcnt  <= '0;
                     end else if (r_dcnt == c_D_LAST) begin
                        r_state    <= S_HELD;
                        r_press    <= 1'b1;
                        r_held     <= 1'b1;
                        r_hcnt     <= '0;
                        r_was_long <= 1'b0;
                     end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                     end
                  end
                  S_HELD: begin
                     if (!w_act) begin
                        r_state <= S_RELEASE_DB;
                        r_dcnt  <= '0;
                     end else if (r_hcnt == c_H_LAST) begin
                        r_state    <= S_LONG;
                        r_long     <= 1'b1;
                        r_rcnt     <= '0;
                        r_was_long <= 1'b1;
                     end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                     end
                  end
                  S_LONG: begin
                     if (!w_act) begin
                        r_state <= S_RELEASE_DB;
                        r_dcnt  <= '0;
                     end else if (r_rcnt == c_R_LAST) begin
                        r_repeat <= c_REP_EN;
                        r_rcnt   <= '0;
                     end else begin
                        r_rcnt <= r_rcnt + 1'b1;
                     end
                  end
                  S_RELEASE_DB: begin
                     // The return edge counts as a hold cycle, so long/repeat
                     // slip by exactly the time spent here.
                     if (w_act) begin
                        if (r_was_long) begin
                           r_state <= S_LONG;
                           if (r_rcnt != c_R_LAST) r_rcnt <= r_rcnt + 1'b1;
                        end else begin
                           r_state <= S_HELD;
                           if (r_hcnt != c_H_LAST) r_hcnt <= r_hcnt + 1'b1;
                        end
                     end else if (r_dcnt == c_D_LAST) begin
                        r_state   <= S_IDLE;
                        r_release <= 1'b1;
                        r_held    <= 1'b0;
                     end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                     end
                  end
                  default: begin
                     r_state <= S_IDLE;
                     r_held  <= 1'b0;
                  end
               endcase
            end
         end

         assign key_press[i]   = r_press;
         assign key_release[i] = r_release;
         assign key_long[i]    = r_long;
         assign key_repeat[i]  = r_repeat;
         assign key_held[i]    = r_held;
      end
   endgenerate

   logic [c_CW-1:0] w_code;

   always_comb begin
      w_code = '0;
      for (int k = N_KEY - 1; k >= 0; k--) begin
         if (key_press[k]) w_code = c_CW'(k);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         key_vld  <= 1'b0;
         key_code <= '0;
      end else begin
         key_vld  <= |key_press;
         key_code <= w_code;
      end
   end

endmodule
`default_nettype wire
